// File: rtl/bv_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bv_scan_ctrl_pkg
// Purpose  : Shared FSM state encoding and default sizes for the bit-vector
//            scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package bv_scan_ctrl_pkg;

   // Default vector width; it must equal 2**DEFAULT_WIDTH_COUNT.
   localparam int DEFAULT_WIDTH       = 64;
   localparam int DEFAULT_WIDTH_COUNT = 6;

   // Scanner FSM encoding.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

endpackage : bv_scan_ctrl_pkg
`default_nettype wire

// File: rtl/bv_lsb_find.sv
`default_nettype none
// ============================================================================
// Module   : bv_lsb_find
// Purpose  : Combinational lowest-set-bit finder. Returns the index of the
//            lowest set bit, a one-hot mask of that bit and a zero flag.
//            For an all-zero vector the index is 0 and the mask is 0.
// Revision : 1.0 - initial release
// ============================================================================
module bv_lsb_find
   import bv_scan_ctrl_pkg::*;
#(
   parameter int width       = DEFAULT_WIDTH,
   parameter int width_count = DEFAULT_WIDTH_COUNT
) (
   input  logic [width-1:0]       vec,
   output logic [width_count-1:0] idx,
   output logic [width-1:0]       onehot,
   output logic                   zero
);

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = vec & (~vec + {{(width-1){1'b0}}, 1'b1});
   assign zero   = (vec == '0);

   // Priority encode from the top down so the lowest set bit wins.
   always_comb begin
      idx = '0;
      for (int i = width - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = width_count'(i);
         end
      end
   end

endmodule : bv_lsb_find
`default_nettype wire

// File: rtl/bv_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bv_scan_ctrl
// Purpose  : Accepts a match bit-vector and emits the index of every set bit,
//            lowest first, as a valid/ready beat stream. An empty vector
//            yields a single "none" beat. Supports synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module bv_scan_ctrl
   import bv_scan_ctrl_pkg::*;
#(
   parameter int width       = DEFAULT_WIDTH,
   parameter int width_count = DEFAULT_WIDTH_COUNT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   bv_valid,
   input  logic [width-1:0]       bv,
   output logic                   bv_ready,
   input  logic                   flush,
   output logic                   idx_valid,
   input  logic                   idx_ready,
   output logic [width_count-1:0] idx,
   output logic                   idx_last,
   output logic                   idx_none,
   output logic [width_count:0]   match_cnt,
   output logic                   busy
);

   logic [0:0]             r_state;
   logic [width-1:0]       r_cur;
   logic                   r_idx_valid;
   logic [width_count-1:0] r_idx;
   logic                   r_idx_last;
   logic                   r_idx_none;
   logic [width_count:0]   r_match_cnt;

   logic [width-1:0]       w_find_in;
   logic [width_count-1:0] w_find_idx;
   logic [width-1:0]       w_find_onehot;
   logic                   w_find_zero;
   logic [width-1:0]       w_rest;
   logic                   w_accept;
   logic                   w_handshake;

   // While idle the finder looks at the offered vector, otherwise at the
   // remaining bits of the vector being scanned.
   assign w_find_in   = (r_state == ST_EMIT) ? r_cur : bv;
   assign w_rest      = w_find_in & ~w_find_onehot;
   assign w_accept    = (r_state == ST_IDLE) && bv_valid;
   assign w_handshake = r_idx_valid && idx_ready;

   bv_lsb_find #(
      .width       (width),
      .width_count (width_count)
   ) u_lsb_find (
      .vec    (w_find_in),
      .idx    (w_find_idx),
      .onehot (w_find_onehot),
      .zero   (w_find_zero)
   );

   // Scanner state, remaining-bit register and registered beat outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cur       <= '0;
         r_idx_valid <= 1'b0;
         r_idx       <= '0;
         r_idx_last  <= 1'b0;
         r_idx_none  <= 1'b0;
         r_match_cnt <= '0;
      end else if (flush) begin
         // Flush overrides any accept or handshake in the same cycle.
         r_state     <= ST_IDLE;
         r_cur       <= '0;
         r_idx_valid <= 1'b0;
         r_match_cnt <= '0;
      end else if (w_accept) begin
         r_state     <= ST_EMIT;
         r_idx_valid <= 1'b1;
         r_idx       <= w_find_idx;
         r_cur       <= w_rest;
         r_idx_last  <= (w_rest == '0);
         r_idx_none  <= w_find_zero;
         r_match_cnt <= '0;
      end else if (w_handshake) begin
         r_match_cnt <= r_match_cnt + {{width_count{1'b0}}, 1'b1};
         if (r_idx_last) begin
            r_state     <= ST_IDLE;
            r_idx_valid <= 1'b0;
            r_cur       <= '0;
         end else begin
            r_idx      <= w_find_idx;
            r_cur      <= w_rest;
            r_idx_last <= (w_rest == '0);
            r_idx_none <= 1'b0;
         end
      end
   end

   assign bv_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign idx_valid = r_idx_valid;
   assign idx       = r_idx;
   assign idx_last  = r_idx_last;
   assign idx_none  = r_idx_none;
   assign match_cnt = r_match_cnt;

endmodule : bv_scan_ctrl
`default_nettype wire

// File: tb/tb_bv_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bv_scan_ctrl
// Purpose  : Self-checking bench for bv_scan_ctrl. The reference is a queue
//            of set-bit positions computed directly from each vector.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bv_scan_ctrl;

   logic        clk;
   logic        reset;
   logic        bv_valid;
   logic [63:0] bv;
   logic        bv_ready;
   logic        flush;
   logic        idx_valid;
   logic        idx_ready;
   logic [5:0]  idx;
   logic        idx_last;
   logic        idx_none;
   logic [6:0]  match_cnt;
   logic        busy;

   int n_vec  = 0;
   int n_miss = 0;

   bv_scan_ctrl #(
      .width       (64),
      .width_count (6)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bv_valid  (bv_valid),
      .bv        (bv),
      .bv_ready  (bv_ready),
      .flush     (flush),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .idx       (idx),
      .idx_last  (idx_last),
      .idx_none  (idx_none),
      .match_cnt (match_cnt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one vector, then walk the expected beat list with random
   // backpressure and random (ignored) offers of new vectors during EMIT.
   task automatic drive_vector(input logic [63:0] vec, input int ready_pct, input string tag);
      int   exp_q[$];
      int   total;
      int   popped;
      int   guard;
      logic empty;
      exp_q = {};
      for (int i = 0; i < 64; i++) if (vec[i]) exp_q.push_back(i);
      empty = (exp_q.size() == 0);
      if (empty) exp_q.push_back(0);
      total = exp_q.size();

      n_vec++;
      if (bv_ready !== 1'b1 || idx_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL %s idle-before-offer: bv_ready=%b idx_valid=%b want 1/0", tag, bv_ready, idx_valid);
      end
      bv_valid = 1'b1; bv = vec; idx_ready = 1'b0;
      @(negedge clk);
      bv_valid = 1'b0;
      popped = 0; guard = 0;
      while (exp_q.size() > 0 && guard < 2000) begin
         guard++;
         n_vec++;
         if (idx_valid !== 1'b1 || idx !== 6'(exp_q[0]) || idx_last !== (exp_q.size() == 1) ||
             idx_none !== empty || match_cnt !== 7'(popped) || bv_ready !== 1'b0 || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL %s beat%0d: valid=%b idx=%0d last=%b none=%b cnt=%0d rdy=%b busy=%b want 1 %0d %b %b %0d 0 1",
                     tag, popped, idx_valid, idx, idx_last, idx_none, match_cnt, bv_ready, busy,
                     exp_q[0], (exp_q.size() == 1), empty, popped);
         end
         idx_ready = ($urandom_range(99) < ready_pct);
         bv_valid  = $urandom_range(1);
         bv        = {$urandom, $urandom};
         @(negedge clk);
         if (idx_ready) begin
            void'(exp_q.pop_front());
            popped++;
         end
      end
      idx_ready = 1'b0; bv_valid = 1'b0;
      n_vec++;
      if (guard >= 2000) begin
         n_miss++;
         $display("FAIL %s timeout: %0d beats outstanding, want 0", tag, exp_q.size());
      end
      n_vec++;
      if (idx_valid !== 1'b0 || bv_ready !== 1'b1 || busy !== 1'b0 || match_cnt !== 7'(total)) begin
         n_miss++;
         $display("FAIL %s done: valid=%b rdy=%b busy=%b cnt=%0d want 0 1 0 %0d",
                  tag, idx_valid, bv_ready, busy, match_cnt, total);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bv_valid = 1'b0; bv = '0; flush = 1'b0; idx_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (idx_valid !== 0 || idx !== 0 || idx_last !== 0 || idx_none !== 0 || match_cnt !== 0 ||
          bv_ready !== 1 || busy !== 0) begin
         n_miss++;
         $display("FAIL reset_state: valid=%b idx=%0d last=%b none=%b cnt=%0d rdy=%b busy=%b want 0 0 0 0 0 1 0",
                  idx_valid, idx, idx_last, idx_none, match_cnt, bv_ready, busy);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sparse();
      drive_vector(64'h0000_0000_0000_0029, 100, "sparse_29");
   endtask

   task automatic test_empty();
      drive_vector(64'h0, 100, "empty");
      drive_vector(64'h0, 40, "empty_bp");
   endtask

   task automatic test_backpressure();
      bv_valid = 1'b1; bv = 64'h8000_0000_0000_0001; idx_ready = 1'b0;
      @(negedge clk);
      bv_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (idx_valid !== 1'b1 || idx !== 6'd0 || idx_last !== 1'b0 || match_cnt !== 7'd0) begin
            n_miss++;
            $display("FAIL bp_hold c%0d: valid=%b idx=%0d last=%b cnt=%0d want 1 0 0 0",
                     c, idx_valid, idx, idx_last, match_cnt);
         end
         @(negedge clk);
      end
      idx_ready = 1'b1;
      n_vec++;
      if (idx_valid !== 1'b1 || idx !== 6'd0 || idx_last !== 1'b0) begin
         n_miss++;
         $display("FAIL bp_first: valid=%b idx=%0d last=%b want 1 0 0", idx_valid, idx, idx_last);
      end
      @(negedge clk);
      n_vec++;
      if (idx_valid !== 1'b1 || idx !== 6'd63 || idx_last !== 1'b1 || match_cnt !== 7'd1) begin
         n_miss++;
         $display("FAIL bp_second: valid=%b idx=%0d last=%b cnt=%0d want 1 63 1 1",
                  idx_valid, idx, idx_last, match_cnt);
      end
      @(negedge clk);
      idx_ready = 1'b0;
      n_vec++;
      if (idx_valid !== 1'b0 || bv_ready !== 1'b1 || match_cnt !== 7'd2) begin
         n_miss++;
         $display("FAIL bp_done: valid=%b rdy=%b cnt=%0d want 0 1 2", idx_valid, bv_ready, match_cnt);
      end
   endtask

   task automatic test_all_ones();
      int busy_cycles;
      bv_valid = 1'b1; bv = '1; idx_ready = 1'b1;
      @(negedge clk);
      bv_valid = 1'b0;
      busy_cycles = 0;
      while (busy === 1'b1 && busy_cycles < 200) begin
         n_vec++;
         if (idx !== 6'(busy_cycles) || idx_last !== (busy_cycles == 63) || match_cnt !== 7'(busy_cycles)) begin
            n_miss++;
            $display("FAIL ones_beat%0d: idx=%0d last=%b cnt=%0d want %0d %b %0d",
                     busy_cycles, idx, idx_last, match_cnt, busy_cycles, (busy_cycles == 63), busy_cycles);
         end
         busy_cycles++;
         @(negedge clk);
      end
      idx_ready = 1'b0;
      n_vec++;
      if (busy_cycles != 64 || match_cnt !== 7'd64) begin
         n_miss++;
         $display("FAIL ones_total: busy_cycles=%0d cnt=%0d want 64 64", busy_cycles, match_cnt);
      end
   endtask

   task automatic test_flush();
      bv_valid = 1'b1; bv = 64'h0F; idx_ready = 1'b1;
      @(negedge clk);
      bv_valid = 1'b0;
      n_vec++;
      if (idx_valid !== 1'b1 || idx !== 6'd0) begin
         n_miss++;
         $display("FAIL flush_beat0: valid=%b idx=%0d want 1 0", idx_valid, idx);
      end
      @(negedge clk);
      n_vec++;
      if (idx_valid !== 1'b1 || idx !== 6'd1) begin
         n_miss++;
         $display("FAIL flush_beat1: valid=%b idx=%0d want 1 1", idx_valid, idx);
      end
      flush = 1'b1; bv_valid = 1'b1; bv = 64'h5;
      @(negedge clk);
      flush = 1'b0; bv_valid = 1'b0;
      n_vec++;
      if (idx_valid !== 1'b0 || busy !== 1'b0 || bv_ready !== 1'b1 || match_cnt !== 7'd0) begin
         n_miss++;
         $display("FAIL flush_idle: valid=%b busy=%b rdy=%b cnt=%0d want 0 0 1 0",
                  idx_valid, busy, bv_ready, match_cnt);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if (idx_valid !== 1'b0 || busy !== 1'b0) begin
         n_miss++;
         $display("FAIL flush_no_accept: valid=%b busy=%b want 0 0", idx_valid, busy);
      end
      idx_ready = 1'b0;
   endtask

   task automatic test_reset_mid_emit();
      bv_valid = 1'b1; bv = 64'hFF00; idx_ready = 1'b1;
      @(negedge clk);
      bv_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if (idx_valid !== 0 || idx !== 0 || idx_last !== 0 || idx_none !== 0 || match_cnt !== 0 ||
          busy !== 0 || bv_ready !== 1) begin
         n_miss++;
         $display("FAIL rst_async: valid=%b idx=%0d last=%b none=%b cnt=%0d busy=%b rdy=%b want 0 0 0 0 0 0 1",
                  idx_valid, idx, idx_last, idx_none, match_cnt, busy, bv_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (idx_valid !== 1'b0 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_quiet c%0d: valid=%b busy=%b want 0 0", c, idx_valid, busy);
         end
      end
      idx_ready = 1'b0;
      drive_vector(64'h0000_0000_0001_0400, 100, "after_reset");
   endtask

   task automatic test_random();
      logic [63:0] v;
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(3))
            0: v = {$urandom, $urandom};
            1: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            2: v = 64'h1 << $urandom_range(63);
            default: v = ($urandom_range(3) == 0) ? 64'h0 : {32'h0, $urandom};
         endcase
         drive_vector(v, $urandom_range(100, 30), $sformatf("rand%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_sparse();
      test_empty();
      test_backpressure();
      test_all_ones();
      test_flush();
      test_reset_mid_emit();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_bv_scan_ctrl
`default_nettype wire

// File: doc/bv_scan_ctrl.md
BV_SCAN_CTRL -- requirements
Module: bv_scan_ctrl

Interface
REQ-001 Parameter width, default 64, bit-vector width.
REQ-002 Parameter width_count, default 6, index width; width SHALL equal 2**width_count.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 bv_valid  input  1  match vector offered.
REQ-006 bv  input  width  match vector; bit i set means rule i matched.
REQ-007 bv_ready  output  1  block can accept a vector.
REQ-008 flush  input  1  synchronous abort of the current vector.
REQ-009 idx_valid  output  1  index beat valid.
REQ-010 idx_ready  input  1  downstream accepts the beat.
REQ-011 idx  output  width_count  position of a set bit.
REQ-012 idx_last  output  1  final beat for the current vector.
REQ-013 idx_none  output  1  vector contained no set bits.
REQ-014 match_cnt  output  width_count+1  beats handshaken for the current vector.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Two-state FSM: IDLE and EMIT.
REQ-017 IDLE: bv_ready=1, idx_valid=0; EMIT: bv_ready=0, idx_valid=1.
REQ-018 Accept occurs when bv_valid&bv_ready at a clock edge; next cycle state=EMIT and the first beat is presented (latency 1).
REQ-019 On accept: idx <= index of lowest set bit of bv; remaining-vector register cur <= bv with that bit cleared; idx_last <= (cleared vector == 0); idx_none <= (bv == 0); match_cnt <= 0.
REQ-020 Empty vector (bv == 0): exactly one beat, idx=0, idx_none=1, idx_last=1.
REQ-021 Beat handshake occurs when idx_valid&idx_ready; match_cnt increments by 1 at each handshake, including the idx_none beat.
REQ-022 Handshake with idx_last=0: idx <= lowest set bit of cur, cur <= cur with that bit cleared, idx_last <= (new cur == 0), idx_none <= 0.
REQ-023 Handshake with idx_last=1: next state IDLE, cur <= 0.
REQ-024 match_cnt holds its value in IDLE until the next accept.
REQ-025 idx_valid=1 with idx_ready=0: idx, idx_last, idx_none and cur SHALL hold unchanged.
REQ-026 With idx_ready held high, beats SHALL issue one per cycle in ascending index order.
REQ-027 No new vector SHALL be accepted during EMIT; the earliest accept is the cycle after the last handshake.
REQ-028 flush=1 in any state: next state IDLE, idx_valid=0, cur=0, match_cnt=0.
REQ-029 flush takes priority over a simultaneous handshake or accept; a vector offered in the flush cycle is not accepted.
REQ-030 bv with all 64 bits set SHALL produce 64 beats (idx 0..63), final match_cnt=64 with no overflow.
REQ-031 All outputs SHALL be registered, except bv_ready and busy, which are decoded from state only.

Reset
REQ-032 Reset low asynchronously forces state=IDLE, idx_valid=0, idx=0, idx_last=0, idx_none=0, match_cnt=0, cur=0.
REQ-033 After reset, bv_ready=1 and busy=0.
REQ-034 Reset asserted mid-EMIT discards the remaining bits; no beat is emitted after reset release until a new accept.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE, EMIT) and default values for width and width_count.
REQ-036 One sub-module bv_lsb_find (combinational: width-bit vector in; index, one-hot mask and zero flag out) SHALL be instantiated once.
REQ-037 The sub-module's input SHALL be muxed between bv (IDLE) and cur (EMIT).

Verification
REQ-038 bv=64'h0000_0000_0000_0029, idx_ready=1 -> beats idx 0,3,5 on three consecutive cycles; last on 5; match_cnt=3; bv_ready=1 the next cycle.
REQ-039 bv=0 -> one beat, idx=0, idx_none=1, idx_last=1; match_cnt=1.
REQ-040 bv=64'h8000_0000_0000_0001, idx_ready low for 4 cycles -> idx=0 held stable for 4 cycles; then idx 0 and 63 issue; 63 carries idx_last.
REQ-041 bv all ones, idx_ready=1 -> 64 beats idx 0..63; match_cnt=64; busy high for exactly 64 cycles.
REQ-042 flush asserted on the second beat of bv=64'h0F, with bv_valid also high -> no further beats; IDLE next cycle; offered vector not accepted.
REQ-043 reset pulsed low mid-EMIT of bv=64'hFF00 -> all outputs zero immediately; no beats after release until a new vector is accepted.
